// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, constants and address check for the memory arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W   = 13;
    localparam int DEF_MAX_WAIT = 4;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // A byte address is bad when it is not word aligned or lies above the memory.
    function automatic logic addr_bad(input logic [31:0] addr, input int addr_w);
        logic [31:0] w_hi;
        w_hi = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (w_hi != 32'd0);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - data-first grant logic with fetch anti-starvation counter
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_if_valid,
    input  logic i_d_valid,
    input  logic i_idle,
    output logic o_grant_if,
    output logic o_grant_d
);

    localparam logic [3:0] W_MAX = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       w_if_prio;

    // Fetch takes over once it has lost MAX_WAIT rounds in a row.
    assign w_if_prio  = (r_wait_cnt == W_MAX);
    assign o_grant_if = i_idle & i_if_valid & (~i_d_valid | w_if_prio);
    assign o_grant_d  = i_idle & i_d_valid & ~(i_if_valid & w_if_prio);

    // Count data wins that left a fetch waiting; a fetch grant resets the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (o_grant_if) begin
            r_wait_cnt <= 4'd0;
        end else if (o_grant_d && i_if_valid && (r_wait_cnt != W_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter and sequencer for the single-port main memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic [31:0] mem_address,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    state_t      r_state;
    logic        r_port;
    logic        r_we;

    logic        w_idle;
    logic        w_grant_if;
    logic        w_grant_d;
    logic        w_accept;
    logic        w_we;
    logic [31:0] w_addr;
    logic        w_err;
    logic        w_rsp_take;

    assign w_idle = (r_state == IDLE);

    mem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_if_valid (if_req_valid),
        .i_d_valid  (d_req_valid),
        .i_idle     (w_idle),
        .o_grant_if (w_grant_if),
        .o_grant_d  (w_grant_d)
    );

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;
    assign w_accept     = w_grant_if | w_grant_d;

    // Winner's request fields; fetch never writes.
    assign w_we       = w_grant_d & d_req_we;
    assign w_addr     = w_grant_d ? d_req_addr : if_req_addr;
    assign w_err      = addr_bad(w_addr, ADDR_W);
    assign w_rsp_take = (r_port == PORT_D) ? d_rsp_ready : if_rsp_ready;

    // Sequencer: accept in IDLE, one memory cycle in ACCESS, hold the response in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_port           <= PORT_IF;
            r_we             <= 1'b0;
            if_rsp_valid     <= 1'b0;
            if_rsp_data      <= 32'd0;
            if_rsp_err       <= 1'b0;
            d_rsp_valid      <= 1'b0;
            d_rsp_data       <= 32'd0;
            d_rsp_err        <= 1'b0;
            mem_address      <= 32'd0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_data_in      <= 32'd0;
            busy             <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_port <= w_grant_d ? PORT_D : PORT_IF;
                        r_we   <= w_we;
                        busy   <= 1'b1;
                        if (w_err) begin
                            // Bad address: answer straight away without touching memory.
                            r_state <= RESP;
                            if (w_grant_d) begin
                                d_rsp_valid <= 1'b1;
                                d_rsp_data  <= 32'd0;
                                d_rsp_err   <= 1'b1;
                            end else begin
                                if_rsp_valid <= 1'b1;
                                if_rsp_data  <= 32'd0;
                                if_rsp_err   <= 1'b1;
                            end
                        end else begin
                            r_state          <= ACCESS;
                            mem_address      <= 32'(w_addr[ADDR_W+1:2]);
                            mem_read_enable  <= ~w_we;
                            mem_write_enable <= w_we;
                            if (w_we) begin
                                mem_data_in <= d_req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    r_state          <= RESP;
                    mem_read_enable  <= 1'b0;
                    mem_write_enable <= 1'b0;
                    if (r_port == PORT_D) begin
                        d_rsp_valid <= 1'b1;
                        d_rsp_data  <= r_we ? 32'd0 : mem_data_out;
                        d_rsp_err   <= 1'b0;
                    end else begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= mem_data_out;
                        if_rsp_err   <= 1'b0;
                    end
                end
                RESP: begin
                    if (w_rsp_take) begin
                        r_state      <= IDLE;
                        busy         <= 1'b0;
                        if_rsp_valid <= 1'b0;
                        if_rsp_data  <= 32'd0;
                        if_rsp_err   <= 1'b0;
                        d_rsp_valid  <= 1'b0;
                        d_rsp_data   <= 32'd0;
                        d_rsp_err    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for the fetch/data memory arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read_enable, mem_write_enable, busy;

    mem_arbiter dut (
        .clk (clk), .rst_n (rst_n),
        .if_req_valid (if_req_valid), .if_req_ready (if_req_ready), .if_req_addr (if_req_addr),
        .if_rsp_valid (if_rsp_valid), .if_rsp_ready (if_rsp_ready), .if_rsp_data (if_rsp_data),
        .if_rsp_err (if_rsp_err),
        .d_req_valid (d_req_valid), .d_req_ready (d_req_ready), .d_req_we (d_req_we),
        .d_req_addr (d_req_addr), .d_req_wdata (d_req_wdata),
        .d_rsp_valid (d_rsp_valid), .d_rsp_ready (d_rsp_ready), .d_rsp_data (d_rsp_data),
        .d_rsp_err (d_rsp_err),
        .mem_address (mem_address), .mem_read_enable (mem_read_enable),
        .mem_write_enable (mem_write_enable), .mem_data_in (mem_data_in),
        .mem_data_out (mem_data_out), .busy (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:8191];
    logic [31:0] ref_mem [0:8191];

    assign mem_data_out = mem[mem_address[12:0]];

    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[12:0]] <= mem_data_in;
    end

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    logic glog[$];
    exp_t mon_e;
    exp_t pop_e;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_8000);
    endfunction

    task automatic sb_pop(input logic port, input logic [31:0] data, input logic err);
        if (sb.size() == 0) begin
            check("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
            pop_e = sb.pop_front();
            check("rsp_port", 32'(port), 32'(pop_e.port));
            check("rsp_data", data, pop_e.data);
            check("rsp_err", 32'(err), 32'(pop_e.err));
        end
    endtask

    // Monitor: push expectations at accept, compare at response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_req_valid && if_req_ready) begin
                mon_e.port = 1'b0;
                mon_e.err  = bad(if_req_addr);
                mon_e.data = mon_e.err ? 32'd0 : ref_mem[if_req_addr[14:2]];
                sb.push_back(mon_e);
                glog.push_back(1'b0);
            end
            if (d_req_valid && d_req_ready) begin
                mon_e.port = 1'b1;
                mon_e.err  = bad(d_req_addr);
                mon_e.data = (mon_e.err || d_req_we) ? 32'd0 : ref_mem[d_req_addr[14:2]];
                if (d_req_we && !mon_e.err) ref_mem[d_req_addr[14:2]] = d_req_wdata;
                sb.push_back(mon_e);
                glog.push_back(1'b1);
            end
            if (if_rsp_valid && if_rsp_ready) sb_pop(1'b0, if_rsp_data, if_rsp_err);
            if (d_rsp_valid && d_rsp_ready) sb_pop(1'b1, d_rsp_data, d_rsp_err);
            if (mem_read_enable && mem_write_enable) check("strobe_excl", 32'd1, 32'd0);
            if (if_rsp_valid && d_rsp_valid) check("rsp_excl", 32'd1, 32'd0);
        end
    end

    task automatic do_req(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic got;
        logic e;
        got = 1'b0;
        e   = bad(addr);
        @(posedge clk); #1;
        if (port) begin
            d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wd;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? d_req_ready : if_req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("req_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        if (e) begin
            check("err_rsp_n1", 32'(port ? d_rsp_valid : if_rsp_valid), 32'd1);
            check("err_no_strobe", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        end else begin
            check("acc_re", 32'(mem_read_enable), 32'(!we));
            check("acc_we", 32'(mem_write_enable), 32'(we));
            check("acc_addr", mem_address, {19'd0, addr[14:2]});
            if (we) check("acc_wdata", mem_data_in, wd);
            check("acc_no_rsp", 32'(port ? d_rsp_valid : if_rsp_valid), 32'd0);
            @(negedge clk);
            check("rsp_n2", 32'(port ? d_rsp_valid : if_rsp_valid), 32'd1);
        end
    endtask

    logic exp_order [10];
    logic got_f;

    initial begin
        rst_n = 1'b0;
        if_req_valid = 1'b0; if_req_addr = 32'd0; if_rsp_ready = 1'b1;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'd0; d_req_wdata = 32'd0;
        d_rsp_ready = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
        mem[0] = 32'h0022_1800;
        for (int i = 0; i < 8192; i++) ref_mem[i] = mem[i];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp", 32'({if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err}), 32'd0);
        check("rst_strobes", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_wdata", mem_data_in, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fetch of word 0, then store/load round trip.
        do_req(1'b0, 1'b0, 32'h0000_0000, 32'd0);
        do_req(1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h0000_0020, 32'd0);

        // Mixed random traffic away from the directed addresses.
        for (int k = 0; k < 6; k++) begin
            logic p;
            p = 1'($urandom_range(0, 1));
            do_req(p, p & 1'($urandom_range(0, 1)),
                   32'h100 + (32'($urandom_range(0, 1000)) << 2), $urandom);
        end

        // Bad addresses on both ports.
        do_req(1'b0, 1'b0, 32'h0000_0006, 32'd0);
        do_req(1'b0, 1'b0, 32'h0000_8000, 32'd0);
        do_req(1'b1, 1'b0, 32'h0000_0006, 32'd0);
        do_req(1'b1, 1'b1, 32'h0000_8000, 32'h1111_2222);

        // Both ports contending continuously.
        glog.delete();
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'h4;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h8;
        for (int i = 0; i < 80 && glog.size() < 10; i++) @(negedge clk);
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        check("grant_count", 32'(glog.size()), 32'd10);
        for (int i = 0; i < 10 && i < glog.size(); i++) begin
            check($sformatf("grant_%0d", i), 32'(glog[i]), 32'(exp_order[i]));
        end
        repeat (4) @(negedge clk);

        // Response back-pressure while fetch waits.
        @(posedge clk); #1;
        d_rsp_ready = 1'b0;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h20;
        got_f = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d_req_ready) begin got_f = 1'b1; break; end
        end
        check("bp_accept", 32'(got_f), 32'd1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(d_rsp_valid), 32'd1);
            check("bp_data", d_rsp_data, 32'hDEAD_BEEF);
            check("bp_if_ready", 32'(if_req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        d_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_take_no_accept", 32'(if_req_ready), 32'd0);
        got_f = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_req_ready) begin got_f = 1'b1; break; end
        end
        check("bp_fetch_after", 32'(got_f), 32'd1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during the ACCESS cycle of a store.
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h40; d_req_wdata = 32'h1234_5678;
        got_f = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d_req_ready) begin got_f = 1'b1; break; end
        end
        check("rr_accept", 32'(got_f), 32'd1);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        check("rr_in_access", 32'(mem_write_enable), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rr_strobes", 32'({mem_read_enable, mem_write_enable}), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_addr", mem_address, 32'd0);
        check("rr_wdata", mem_data_in, 32'd0);
        check("rr_rsp", 32'({d_rsp_valid, if_rsp_valid}), 32'd0);
        sb.delete();
        ref_mem[16] = mem[16];
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rr_no_rsp", 32'(d_rsp_valid), 32'd0);
        end
        do_req(1'b1, 1'b0, 32'h0000_0020, 32'd0);

        repeat (5) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
